// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: state encoding,
// default datapath width, iteration counter width and the most-negative value.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int CNT_W    = 5;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/cla_full_adder.sv
// Shared adder: WIDTH-bit sum with carry in and carry out. Written
// behaviourally so synthesis can map it onto its fast-carry structure.
module cla_full_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/md_negate32.sv
// Two's-complement negate with enable: passes the value through unchanged
// when the enable is low. Negating the most-negative value returns itself,
// which reads correctly as its unsigned magnitude.
module md_negate32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_en ? (~i_value + WIDTH'(1)) : i_value;

endmodule

// File: rtl/iter_multdiv.sv
// Iterative signed multiply/divide responder. A start pulse latches operand
// magnitudes; WIDTH iterations of shift-add (multiply) or restoring
// subtraction (divide) follow, then one more edge applies sign correction and
// loads the result, and data_resultRDY pulses for one cycle.
module iter_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_last;       // all WIDTH iterations are done
    logic [WIDTH-1:0] r_acc;        // product high half / partial remainder
    logic [WIDTH-1:0] r_q;          // product low half / dividend-quotient shifter
    logic [WIDTH-1:0] r_b_mag;
    logic             r_neg;        // operand signs differ
    logic             r_b_zero;
    logic             r_div_ovf;    // most-negative / -1
    logic [WIDTH-1:0] r_result;
    logic             r_exception;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_shift_rem;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;
    logic             w_mul_exc;

    md_negate32 #(.WIDTH(WIDTH)) u_abs_a (
        .i_value (data_operandA),
        .i_en    (data_operandA[WIDTH-1]),
        .o_value (w_a_mag)
    );

    md_negate32 #(.WIDTH(WIDTH)) u_abs_b (
        .i_value (data_operandB),
        .i_en    (data_operandB[WIDTH-1]),
        .o_value (w_b_mag)
    );

    // Low half of the product and the quotient share one sign-correction negator.
    md_negate32 #(.WIDTH(WIDTH)) u_fix_lo (
        .i_value (r_q),
        .i_en    (r_neg),
        .o_value (w_lo_fix)
    );

    // The high half of a negated 64-bit product only takes the +1 carry when
    // the low half is zero.
    assign w_hi_fix = !r_neg          ? r_acc :
                      (r_q == '0)     ? (~r_acc + WIDTH'(1)) : ~r_acc;

    // Signed product overflows when bits [2*WIDTH-1:WIDTH-1] are not all equal.
    assign w_mul_exc = !((&{w_hi_fix, w_lo_fix[WIDTH-1]}) ||
                         !(|{w_hi_fix, w_lo_fix[WIDTH-1]}));

    assign w_shift_rem = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};

    // Adder operand select: subtract |B| from the shifted remainder when
    // dividing, otherwise conditionally add |B| to the product high half.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_add_a   = r_acc;
        w_add_b   = r_q[0] ? r_b_mag : '0;
        w_add_cin = 1'b0;
        if (r_state == S_DIV) begin
            w_add_a   = w_shift_rem;
            w_add_b   = ~r_b_mag;
            w_add_cin = 1'b1;
        end
    end

    cla_full_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Control FSM and datapath: start from any state, iterate, finalize, pulse.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_acc       <= '0;
            r_q         <= '0;
            r_b_mag     <= '0;
            r_neg       <= 1'b0;
            r_b_zero    <= 1'b0;
            r_div_ovf   <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            r_state   <= ctrl_MULT ? S_MUL : S_DIV;
            r_count   <= '0;
            r_last    <= 1'b0;
            r_acc     <= '0;
            r_q       <= w_a_mag;
            r_b_mag   <= w_b_mag;
            r_neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_b_zero  <= (data_operandB == '0);
            r_div_ovf <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        end else begin
            case (r_state)
                S_MUL: begin
                    if (r_last) begin
                        r_result    <= w_lo_fix;
                        r_exception <= w_mul_exc;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc   <= {w_cout, w_sum[WIDTH-1:1]};
                        r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                        r_count <= r_count + CNT_W'(1);
                        r_last  <= (r_count == LAST_CNT);
                    end
                end
                S_DIV: begin
                    if (r_last) begin
                        r_result    <= r_b_zero ? '0 : w_lo_fix;
                        r_exception <= r_b_zero || r_div_ovf;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc   <= w_cout ? w_sum : w_shift_rem;
                        r_q     <= {r_q[WIDTH-2:0], w_cout};
                        r_count <= r_count + CNT_W'(1);
                        r_last  <= (r_count == LAST_CNT);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == S_DONE);

endmodule

// File: doc/iter_multdiv.md
Name: iter_multdiv

Overview:
- Iterative signed multiply/divide unit: the responder side of the processor's MULT/DIV handshake.
- The execute stage pulses ctrl_MULT or ctrl_DIV with operands. The unit computes over a fixed number of cycles, then pulses data_resultRDY with the result and exception flag.
- Sits beside the ALU in the X stage; the processor stalls on it.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clock  input  1  master clock, rising edge
- reset  input  1  asynchronous, active-low reset
- data_operandA  input  WIDTH  multiplicand / dividend, sampled on start edge only
- data_operandB  input  WIDTH  multiplier / divisor, sampled on start edge only
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- data_result  output  WIDTH  result, registered, held until next completion
- data_exception  output  1  overflow / divide-by-zero flag, registered, held with data_result
- data_resultRDY  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; data_result=0; data_exception=0; data_resultRDY=0; counter=0.
  - Reset mid-operation aborts with no RDY.
- States: IDLE, MUL, DIV, DONE.
- Start:
  - On a rising edge with ctrl_MULT=1 (from any state), latch operands and enter MUL.
  - ctrl_DIV=1 enters DIV the same way.
  - If both are asserted, MULT wins.
  - A start in MUL/DIV/DONE aborts the current operation; no RDY is issued for it.
- Latency:
  - Start edge E0; iteration edges E1..E32 (counter 0..31).
  - E33 loads data_result/data_exception and enters DONE.
  - data_resultRDY=1 for exactly the cycle following E33 (state DONE), then IDLE.
- data_resultRDY is a registered output (state==DONE), never combinational from inputs.
- Multiply (sign-magnitude):
  - Take |A| and |B| as unsigned WIDTH values; |0x80000000| = 0x80000000 unsigned.
  - Radix-2 shift-add over 32 iterations produces a 64-bit unsigned product.
  - At E33, negate if sign(A) xor sign(B).
  - data_result = low 32 bits.
  - data_exception=1 iff bits [63:31] of the signed product are not all equal.
- Divide (restoring, sign-magnitude):
  - 32 iterations of shift remainder, subtract |B|, set quotient bit if non-negative.
  - At E33, negate the quotient if signs differ; truncation is toward zero; the remainder is discarded.
  - B==0: data_exception=1, data_result=0.
  - A==0x80000000, B==-1: data_exception=1, data_result=0x80000000.
- Zero operand in multiply: result 0, no exception.
- Outputs in IDLE/MUL/DIV hold the last completed values; only E33 updates them.
- No operand changes after E0 affect the computation.

Decomposition:
- Shared package (multdiv_pkg):
  - state encoding constants (IDLE, MUL, DIV, DONE);
  - WIDTH default;
  - counter width (5 bits for WIDTH=32);
  - MIN_NEG constant 0x80000000.
- Sub-module md_negate32: two's-complement negate with enable. Instantiated for |A|, |B| and final sign correction.
- The add/subtract step reuses the existing cla_full_adder.
- Control FSM and datapath registers stay in iter_multdiv.

Test Plan:
- ctrl_MULT pulse, A=7, B=-6 (0xFFFFFFFA) -> data_resultRDY high exactly in the cycle after the 33rd edge, data_result=0xFFFFFFD6, data_exception=0; RDY low in all other cycles.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1. Also A=0x80000000, B=1 -> data_result=0x80000000, data_exception=0.
- ctrl_DIV, A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 (-14), data_exception=0. Also A=100, B=-7 -> 0xFFFFFFF2.
- ctrl_DIV, A=5, B=0 -> data_result=0, data_exception=1. Also A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1.
- ctrl_MULT (3*4), then ctrl_DIV A=20, B=3 ten cycles later -> exactly one RDY, 33 cycles after the DIV start, data_result=6; no RDY for the aborted multiply.
- Start multiply, drive reset low at iteration 15 -> outputs 0 immediately (asynchronous); release, no RDY afterward; a new ctrl_MULT 2*2 completes normally with result 4.
